// File: rtl/vga_pkg.sv
// Shared definitions for the VGA memory subsystem: SRAM geometry, arbiter
// state encoding and the default framebuffer/font locations.
package vga_pkg;

  localparam int SRAM_ADR_W = 19;

  localparam logic [SRAM_ADR_W-1:0] FB_BASE_ADR   = 19'h20000;
  localparam logic [SRAM_ADR_W-1:0] FONT_BASE_ADR = 19'h40000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VGA_RD  = 3'd1,
    CPU_RD  = 3'd2,
    CPU_WR  = 3'd3,
    CPU_ACK = 3'd4
  } arb_state_t;

endpackage

// File: rtl/vga_sram_arbiter.sv
// Single-port SRAM arbiter in the pixel-clock domain: VGA fetch always wins,
// the CPU port is served in free slots, one SRAM access per clock.
module vga_sram_arbiter
  import vga_pkg::*;
#(
  parameter int ADR_W        = SRAM_ADR_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             I_vga_clk,
  input  logic             I_reset,
  input  logic             I_vga_req,
  input  logic [ADR_W-1:0] I_vga_adr,
  output logic [7:0]       O_vga_dat,
  input  logic             I_cpu_req,
  input  logic             I_cpu_we,
  input  logic [ADR_W-1:0] I_cpu_adr,
  input  logic [7:0]       I_cpu_dat,
  output logic             O_cpu_ack,
  output logic [7:0]       O_cpu_dat,
  output logic [ADR_W-1:0] O_sram_adr,
  output logic [7:0]       O_sram_dat,
  output logic             O_sram_dat_oe,
  input  logic [7:0]       I_sram_dat,
  output logic             O_sram_oe_n,
  output logic             O_sram_we_n,
  output logic             O_vga_overrun,
  output logic             O_cpu_starved
);

  localparam logic [7:0] STARVE_LIM_8 = 8'(STARVE_LIMIT);

  arb_state_t state, state_d;
  logic       cpu_busy;
  logic       cpu_block;
  logic       cpu_grant;
  logic       cpu_wait;
  logic [7:0] starve_cnt, starve_cnt_d;
  logic       vga_req_p1;

  // While ack is visible the requester still holds its old req, so the CPU
  // must not be re-granted in that cycle even if VGA displaced CPU_ACK.
  always_comb begin
    state_d      = IDLE;
    cpu_busy     = (state == CPU_RD) || (state == CPU_WR);
    cpu_block    = (state == CPU_ACK) || O_cpu_ack;
    if (I_vga_req)
      state_d = VGA_RD;
    else if (cpu_busy)
      state_d = CPU_ACK;
    else if (I_cpu_req && !cpu_block)
      state_d = I_cpu_we ? CPU_WR : CPU_RD;
    cpu_grant    = (state_d == CPU_RD) || (state_d == CPU_WR);
    cpu_wait     = I_cpu_req && !cpu_grant && !cpu_block && !cpu_busy;
    starve_cnt_d = starve_cnt;
    if (cpu_grant)
      starve_cnt_d = 8'd0;
    else if (cpu_wait && starve_cnt != 8'hFF)
      starve_cnt_d = starve_cnt + 8'd1;
  end

  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      state         <= IDLE;
      O_sram_adr    <= '0;
      O_sram_dat    <= 8'd0;
      O_sram_dat_oe <= 1'b0;
      O_sram_oe_n   <= 1'b1;
      O_sram_we_n   <= 1'b1;
      O_vga_dat     <= 8'd0;
      O_cpu_dat     <= 8'd0;
      O_cpu_ack     <= 1'b0;
      O_vga_overrun <= 1'b0;
      O_cpu_starved <= 1'b0;
      starve_cnt    <= 8'd0;
      vga_req_p1    <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state_d)
        VGA_RD: begin
          O_sram_adr    <= I_vga_adr;
          O_sram_oe_n   <= 1'b0;
          O_sram_we_n   <= 1'b1;
          O_sram_dat_oe <= 1'b0;
        end
        CPU_RD: begin
          O_sram_adr    <= I_cpu_adr;
          O_sram_oe_n   <= 1'b0;
          O_sram_we_n   <= 1'b1;
          O_sram_dat_oe <= 1'b0;
        end
        CPU_WR: begin
          O_sram_adr    <= I_cpu_adr;
          O_sram_dat    <= I_cpu_dat;
          O_sram_dat_oe <= 1'b1;
          O_sram_oe_n   <= 1'b1;
          O_sram_we_n   <= 1'b0;
        end
        default: begin
          O_sram_oe_n   <= 1'b1;
          O_sram_we_n   <= 1'b1;
          O_sram_dat_oe <= 1'b0;
        end
      endcase
      if (state == VGA_RD) O_vga_dat <= I_sram_dat;
      if (state == CPU_RD) O_cpu_dat <= I_sram_dat;
      O_cpu_ack     <= cpu_busy;
      starve_cnt    <= starve_cnt_d;
      O_cpu_starved <= O_cpu_starved | (starve_cnt_d >= STARVE_LIM_8);
      O_vga_overrun <= O_vga_overrun | (I_vga_req & vga_req_p1);
      vga_req_p1    <= I_vga_req;
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Bench for vga_sram_arbiter: asynchronous SRAM model, bus-ownership reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_vga_sram_arbiter;
  import vga_pkg::*;

  localparam int AW    = 19;
  localparam int LIMIT = 64;

  logic          I_vga_clk = 1'b0;
  logic          I_reset   = 1'b1;
  logic          I_vga_req = 1'b0;
  logic [AW-1:0] I_vga_adr = '0;
  logic [7:0]    O_vga_dat;
  logic          I_cpu_req = 1'b0;
  logic          I_cpu_we  = 1'b0;
  logic [AW-1:0] I_cpu_adr = '0;
  logic [7:0]    I_cpu_dat = 8'd0;
  logic          O_cpu_ack;
  logic [7:0]    O_cpu_dat;
  logic [AW-1:0] O_sram_adr;
  logic [7:0]    O_sram_dat;
  logic          O_sram_dat_oe;
  logic [7:0]    I_sram_dat;
  logic          O_sram_oe_n, O_sram_we_n;
  logic          O_vga_overrun, O_cpu_starved;

  int checks = 0;
  int errors = 0;

  vga_sram_arbiter #(.ADR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .I_vga_clk(I_vga_clk), .I_reset(I_reset),
    .I_vga_req(I_vga_req), .I_vga_adr(I_vga_adr), .O_vga_dat(O_vga_dat),
    .I_cpu_req(I_cpu_req), .I_cpu_we(I_cpu_we), .I_cpu_adr(I_cpu_adr),
    .I_cpu_dat(I_cpu_dat), .O_cpu_ack(O_cpu_ack), .O_cpu_dat(O_cpu_dat),
    .O_sram_adr(O_sram_adr), .O_sram_dat(O_sram_dat),
    .O_sram_dat_oe(O_sram_dat_oe), .I_sram_dat(I_sram_dat),
    .O_sram_oe_n(O_sram_oe_n), .O_sram_we_n(O_sram_we_n),
    .O_vga_overrun(O_vga_overrun), .O_cpu_starved(O_cpu_starved)
  );

  always #5 I_vga_clk = ~I_vga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM: reads are combinational while oe_n is low, writes
  // land while we_n is low with the data pins driven.
  logic [7:0] mem [0:524287];
  assign I_sram_dat = O_sram_oe_n ? 8'hEE : mem[O_sram_adr];

  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = 8'(i * 7 + 3);
    mem[19'h20000] = 8'h5A;
    mem[19'h20001] = 8'h77;
    mem[19'h00010] = 8'h3C;
    forever begin
      @(negedge I_vga_clk);
      if (!O_sram_we_n && O_sram_dat_oe) mem[O_sram_adr] = O_sram_dat;
    end
  end

  // Reference model: who owns the bus this cycle, and what completes at the edge.
  int            owner;   // 0 none, 1 VGA read, 2 CPU read, 3 CPU write
  bit            model_ok = 1'b0;
  bit            done, blocked, prev_vga;
  int            m_wait;
  logic [AW-1:0] m_adr;
  logic [7:0]    m_wdat, m_vga_dat, m_cpu_dat;
  logic          m_oe_n, m_we_n, m_doe, m_ack, m_ovr, m_starved;

  always @(posedge I_vga_clk) begin
    if (I_reset) begin
      model_ok = 1'b1; owner = 0; m_wait = 0; prev_vga = 1'b0;
      m_adr = '0; m_wdat = 8'd0; m_vga_dat = 8'd0; m_cpu_dat = 8'd0;
      m_oe_n = 1'b1; m_we_n = 1'b1; m_doe = 1'b0; m_ack = 1'b0;
      m_ovr = 1'b0; m_starved = 1'b0;
    end else if (model_ok) begin
      done    = (owner == 2) || (owner == 3);
      blocked = done || m_ack;
      if (owner == 1) m_vga_dat = mem[m_adr];
      if (owner == 2) m_cpu_dat = mem[m_adr];
      m_ack = done;
      if (I_vga_req) begin
        owner = 1; m_adr = I_vga_adr; m_oe_n = 1'b0; m_we_n = 1'b1; m_doe = 1'b0;
      end else if (I_cpu_req && !blocked) begin
        m_adr = I_cpu_adr;
        if (I_cpu_we) begin
          owner = 3; m_wdat = I_cpu_dat; m_oe_n = 1'b1; m_we_n = 1'b0; m_doe = 1'b1;
        end else begin
          owner = 2; m_oe_n = 1'b0; m_we_n = 1'b1; m_doe = 1'b0;
        end
      end else begin
        owner = 0; m_oe_n = 1'b1; m_we_n = 1'b1; m_doe = 1'b0;
      end
      if (owner >= 2) m_wait = 0;
      else if (I_cpu_req && !blocked && m_wait < 255) m_wait++;
      if (m_wait >= LIMIT) m_starved = 1'b1;
      if (I_vga_req && prev_vga) m_ovr = 1'b1;
      prev_vga = I_vga_req;
    end
  end

  always @(negedge I_vga_clk) begin
    if (model_ok) begin
      chk("sram_adr", 32'(O_sram_adr), 32'(m_adr));
      chk("sram_dat", 32'(O_sram_dat), 32'(m_wdat));
      chk("sram_oe_n", 32'(O_sram_oe_n), 32'(m_oe_n));
      chk("sram_we_n", 32'(O_sram_we_n), 32'(m_we_n));
      chk("sram_dat_oe", 32'(O_sram_dat_oe), 32'(m_doe));
      chk("vga_dat", 32'(O_vga_dat), 32'(m_vga_dat));
      chk("cpu_ack", 32'(O_cpu_ack), 32'(m_ack));
      chk("cpu_dat", 32'(O_cpu_dat), 32'(m_cpu_dat));
      chk("vga_overrun", 32'(O_vga_overrun), 32'(m_ovr));
      chk("cpu_starved", 32'(O_cpu_starved), 32'(m_starved));
      chk("oe_vs_dat_oe", 32'(O_sram_dat_oe && !O_sram_oe_n), 32'd0);
    end
  end

  int acks, consec;
  bit prev_ack, got_ack;

  initial begin
    repeat (3) @(negedge I_vga_clk);
    chk("rst_oe_n", 32'(O_sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(O_sram_we_n), 32'd1);
    chk("rst_dat_oe", 32'(O_sram_dat_oe), 32'd0);
    chk("rst_adr", 32'(O_sram_adr), 32'd0);
    chk("rst_vga_dat", 32'(O_vga_dat), 32'd0);
    chk("rst_ack", 32'(O_cpu_ack), 32'd0);
    chk("rst_flags", 32'({O_vga_overrun, O_cpu_starved}), 32'd0);
    I_reset = 1'b0;
    @(negedge I_vga_clk);

    // VGA read of the framebuffer base
    I_vga_req = 1'b1; I_vga_adr = FB_BASE_ADR;
    @(negedge I_vga_clk);
    I_vga_req = 1'b0;
    chk("vga_pin_adr", 32'(O_sram_adr), 32'h20000);
    chk("vga_pin_oe_n", 32'(O_sram_oe_n), 32'd0);
    @(negedge I_vga_clk);
    chk("vga_read_dat", 32'(O_vga_dat), 32'h5A);
    @(negedge I_vga_clk);

    // Collision: VGA first, CPU afterwards
    I_vga_req = 1'b1; I_vga_adr = 19'h20001;
    I_cpu_req = 1'b1; I_cpu_we = 1'b0; I_cpu_adr = 19'h00010;
    @(negedge I_vga_clk);
    I_vga_req = 1'b0;
    chk("coll_vga_first", 32'(O_sram_adr), 32'h20001);
    @(negedge I_vga_clk);
    chk("coll_cpu_adr", 32'(O_sram_adr), 32'h00010);
    chk("coll_vga_dat", 32'(O_vga_dat), 32'h77);
    chk("coll_no_early_ack", 32'(O_cpu_ack), 32'd0);
    @(negedge I_vga_clk);
    chk("coll_ack", 32'(O_cpu_ack), 32'd1);
    chk("coll_cpu_dat", 32'(O_cpu_dat), 32'h3C);
    I_cpu_req = 1'b0;
    repeat (2) @(negedge I_vga_clk);

    // Write then immediate VGA read of the same location
    I_cpu_req = 1'b1; I_cpu_we = 1'b1; I_cpu_adr = 19'h00100; I_cpu_dat = 8'hA5;
    @(negedge I_vga_clk);
    chk("wr_we_n", 32'(O_sram_we_n), 32'd0);
    chk("wr_dat_oe", 32'(O_sram_dat_oe), 32'd1);
    chk("wr_dat", 32'(O_sram_dat), 32'hA5);
    I_vga_req = 1'b1; I_vga_adr = 19'h00100;
    @(negedge I_vga_clk);
    I_vga_req = 1'b0;
    chk("wr_ack", 32'(O_cpu_ack), 32'd1);
    chk("wr_we_n_one_cycle", 32'(O_sram_we_n), 32'd1);
    I_cpu_req = 1'b0; I_cpu_we = 1'b0;
    @(negedge I_vga_clk);
    chk("wr_rd_back", 32'(O_vga_dat), 32'hA5);
    repeat (2) @(negedge I_vga_clk);

    // Graphics-mode traffic with a continuous CPU read stream
    acks = 0; consec = 0; prev_ack = 1'b0;
    I_cpu_req = 1'b1; I_cpu_we = 1'b0; I_cpu_adr = 19'h01000;
    for (int i = 0; i < 640; i++) begin
      I_vga_req = (i % 2 == 0);
      I_vga_adr = 19'(FB_BASE_ADR + 19'(i));
      @(negedge I_vga_clk);
      if (O_cpu_ack) begin
        acks++;
        if (prev_ack) consec++;
        I_cpu_adr = 19'($urandom_range(0, 524287));
      end
      prev_ack = O_cpu_ack;
    end
    I_vga_req = 1'b0; I_cpu_req = 1'b0;
    chk("gfx_ack_min", 32'(acks >= 100), 32'd1);
    chk("gfx_ack_max", 32'(acks <= 320), 32'd1);
    chk("gfx_ack_spacing", 32'(consec), 32'd0);
    chk("gfx_starved", 32'(O_cpu_starved), 32'd0);
    chk("gfx_overrun", 32'(O_vga_overrun), 32'd0);
    repeat (4) @(negedge I_vga_clk);

    // Starvation and overrun: VGA held high for 70 cycles
    I_cpu_req = 1'b1; I_cpu_we = 1'b0; I_cpu_adr = 19'h00055;
    I_vga_req = 1'b1; I_vga_adr = FONT_BASE_ADR;
    for (int i = 0; i < 70; i++) begin
      @(negedge I_vga_clk);
      if (i == 59) chk("starve_not_yet", 32'(O_cpu_starved), 32'd0);
    end
    chk("starve_set", 32'(O_cpu_starved), 32'd1);
    chk("overrun_set", 32'(O_vga_overrun), 32'd1);
    I_vga_req = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge I_vga_clk);
      if (O_cpu_ack) got_ack = 1'b1;
    end
    chk("starve_served", 32'(got_ack), 32'd1);
    chk("starve_dat", 32'(O_cpu_dat), 32'(mem[19'h00055]));
    I_cpu_req = 1'b0;
    repeat (3) @(negedge I_vga_clk);
    chk("sticky_starved", 32'(O_cpu_starved), 32'd1);
    chk("sticky_overrun", 32'(O_vga_overrun), 32'd1);

    // Reset in the middle of a write
    I_cpu_req = 1'b1; I_cpu_we = 1'b1; I_cpu_adr = 19'h00200; I_cpu_dat = 8'h11;
    @(negedge I_vga_clk);
    chk("mid_wr_active", 32'(O_sram_we_n), 32'd0);
    I_reset = 1'b1;
    @(negedge I_vga_clk);
    chk("mid_wr_we_n", 32'(O_sram_we_n), 32'd1);
    chk("mid_wr_dat_oe", 32'(O_sram_dat_oe), 32'd0);
    chk("mid_wr_no_ack", 32'(O_cpu_ack), 32'd0);
    chk("mid_wr_flags", 32'({O_vga_overrun, O_cpu_starved}), 32'd0);
    I_reset = 1'b0; I_cpu_req = 1'b0; I_cpu_we = 1'b0;
    @(negedge I_vga_clk);
    chk("post_rst_no_ack", 32'(O_cpu_ack), 32'd0);
    repeat (3) @(negedge I_vga_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
